// File: rtl/wb_serializer_sched_pkg.sv
// wb_serializer_sched_pkg
//   Shared definitions for the Wishbone transmit scheduler: register
//   addresses, scheduler FSM states, CTRL/STATUS bit positions and the
//   default K28.5 idle word.
package wb_serializer_sched_pkg;

    typedef enum logic [1:0] {
        ADR_TXDATA = 2'd0,
        ADR_CTRL   = 2'd1,
        ADR_STATUS = 2'd2,
        ADR_IDLE   = 2'd3
    } adr_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    // CTRL bit positions
    localparam int unsigned CTRL_ENABLE  = 0;
    localparam int unsigned CTRL_IDLE_EN = 1;
    localparam int unsigned CTRL_FLUSH   = 2;
    localparam int unsigned CTRL_OVF_CLR = 3;

    // STATUS bit positions
    localparam int unsigned STAT_EMPTY    = 8;
    localparam int unsigned STAT_FULL     = 9;
    localparam int unsigned STAT_BUSY     = 10;
    localparam int unsigned STAT_OVF      = 11;
    localparam int unsigned STAT_SENT_LSB = 16;

    // Symbol word: three {k, 8-bit} fields
    localparam int unsigned SYM_W = 27;

    // K28.5 x3
    localparam logic [31:0] IDLE_K285 = 32'h06F3_79BC;

endpackage

// File: rtl/wb_serializer_sched_fifo.sv
// ser_sched_fifo
//   Synchronous FIFO for queued symbol words.
//   Ports: clk/rst (async active-high), push_i/data_i write side,
//   pop_i/data_o read side (data_o is the current head), flush_i clears
//   all entries, full_o/empty_o/level_o reflect registered occupancy.
//   Pushes while full and pops while empty are ignored; flush beats push.
module ser_sched_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned W     = 27
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [W-1:0]             data_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output logic [W-1:0]             data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign level_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push_i && !full_o && !flush_i;
        do_pop   = pop_i && !empty_o;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/wb_serializer_sched.sv
// wb_serializer_sched
//   Wishbone-mapped transmit scheduler feeding a serializer.
//   Wishbone slave: CLK_I, RST_I (async active-high), CYC_I, STB_I, WE_I,
//   ADR_I (bits [1:0] decoded), DAT_I, DAT_O, ACK_O, ERR_O; the handshake
//   is combinational and single-cycle.
//   Serializer side: ser_start_o one-cycle start pulse, ser_data_o word
//   held from start until the next load, ser_eot_i end-of-transmission.
//   Queued words are sent in order; with idle insertion enabled the IDLE
//   register word is sent whenever the queue is empty.
module wb_serializer_sched
    import wb_serializer_sched_pkg::*;
#(
    parameter int unsigned DEPTH        = 8,
    parameter logic [31:0] IDLE_DEFAULT = IDLE_K285
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic        CYC_I,
    input  logic        STB_I,
    input  logic        WE_I,
    input  logic [31:0] ADR_I,
    input  logic [31:0] DAT_I,
    output logic [31:0] DAT_O,
    output logic        ACK_O,
    output logic        ERR_O,
    output logic        ser_start_o,
    output logic [31:0] ser_data_o,
    input  logic        ser_eot_i
);

    localparam int unsigned AW = $clog2(DEPTH);

    adr_e        adr;
    logic        cs, bad_access, wr_ack;
    logic        fifo_push, fifo_pop, fifo_flush, push_overflow;
    logic [SYM_W-1:0] fifo_head;
    logic        fifo_full, fifo_empty;
    logic [AW:0] fifo_level;
    logic [31:0] status;

    state_e      state_q, state_d;
    logic        enable_q, enable_d;
    logic        idle_en_q, idle_en_d;
    logic        overflow_q, overflow_d;
    logic [31:0] idle_q, idle_d;
    logic [31:0] ser_data_q, ser_data_d;
    logic        from_fifo_q, from_fifo_d;
    logic [15:0] sent_cnt_q, sent_cnt_d;

    logic        unused_ok;
    assign unused_ok = ^{ADR_I[31:2], DAT_I[31:SYM_W]};

    assign adr = adr_e'(ADR_I[1:0]);
    assign cs  = CYC_I & STB_I;

    ser_sched_fifo #(
        .DEPTH (DEPTH),
        .W     (SYM_W)
    ) u_fifo (
        .clk     (CLK_I),
        .rst     (RST_I),
        .push_i  (fifo_push),
        .data_i  (DAT_I[SYM_W-1:0]),
        .pop_i   (fifo_pop),
        .flush_i (fifo_flush),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    // Bus decode and read mux
    always_comb begin
        bad_access = ((adr == ADR_TXDATA) && WE_I && fifo_full) ||
                     ((adr == ADR_STATUS) && WE_I) ||
                     ((adr == ADR_TXDATA) && !WE_I);
        ACK_O  = cs && !bad_access;
        ERR_O  = cs && bad_access;
        wr_ack = ACK_O && WE_I;

        fifo_flush    = wr_ack && (adr == ADR_CTRL) && DAT_I[CTRL_FLUSH];
        fifo_push     = wr_ack && (adr == ADR_TXDATA) && !fifo_flush;
        push_overflow = cs && WE_I && (adr == ADR_TXDATA) && fifo_full;

        status                = '0;
        status[3:0]           = 4'(fifo_level);
        status[STAT_EMPTY]    = fifo_empty;
        status[STAT_FULL]     = fifo_full;
        status[STAT_BUSY]     = (state_q != ST_IDLE);
        status[STAT_OVF]      = overflow_q;
        status[31:STAT_SENT_LSB] = sent_cnt_q;

        DAT_O = '0;
        if (cs && !WE_I) begin
            case (adr)
                ADR_CTRL: begin
                    DAT_O[CTRL_ENABLE]  = enable_q;
                    DAT_O[CTRL_IDLE_EN] = idle_en_q;
                end
                ADR_STATUS: DAT_O = status;
                ADR_IDLE:   DAT_O = idle_q;
                default:    DAT_O = '0;
            endcase
        end
    end

    // Register file, FSM and sent counter next-state
    always_comb begin
        enable_d    = enable_q;
        idle_en_d   = idle_en_q;
        overflow_d  = overflow_q;
        idle_d      = idle_q;
        state_d     = state_q;
        ser_data_d  = ser_data_q;
        from_fifo_d = from_fifo_q;
        sent_cnt_d  = sent_cnt_q;
        fifo_pop    = 1'b0;

        if (wr_ack && (adr == ADR_CTRL)) begin
            enable_d  = DAT_I[CTRL_ENABLE];
            idle_en_d = DAT_I[CTRL_IDLE_EN];
            if (DAT_I[CTRL_OVF_CLR]) overflow_d = 1'b0;
        end
        if (wr_ack && (adr == ADR_IDLE)) idle_d = {5'b0, DAT_I[SYM_W-1:0]};
        // Set after the clear so a simultaneous overflow wins.
        if (push_overflow) overflow_d = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (enable_q && !fifo_empty) begin
                    fifo_pop    = 1'b1;
                    ser_data_d  = {5'b0, fifo_head};
                    from_fifo_d = 1'b1;
                    state_d     = ST_START;
                end else if (enable_q && idle_en_q) begin
                    ser_data_d  = idle_q;
                    from_fifo_d = 1'b0;
                    state_d     = ST_START;
                end
            end
            ST_START: state_d = ST_WAIT;
            ST_WAIT: begin
                if (ser_eot_i) begin
                    state_d = ST_IDLE;
                    if (from_fifo_q) sent_cnt_d = sent_cnt_q + 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign ser_start_o = (state_q == ST_START);
    assign ser_data_o  = ser_data_q;

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_q     <= ST_IDLE;
            enable_q    <= 1'b0;
            idle_en_q   <= 1'b0;
            overflow_q  <= 1'b0;
            idle_q      <= IDLE_DEFAULT;
            ser_data_q  <= '0;
            from_fifo_q <= 1'b0;
            sent_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            enable_q    <= enable_d;
            idle_en_q   <= idle_en_d;
            overflow_q  <= overflow_d;
            idle_q      <= idle_d;
            ser_data_q  <= ser_data_d;
            from_fifo_q <= from_fifo_d;
            sent_cnt_q  <= sent_cnt_d;
        end
    end

endmodule
